// File: rtl/mm2s_framer.sv
// mm2s_framer
// Wraps a DMA MM2S pixel stream into a framed word stream for the tx buffer.
// Each frame is emitted as:
//   SOF marker, then LINES lines of LINE_WORDS data words,
//   with an EOL marker between lines, then an EOF marker.
// Marker words carry their control byte in all four lanes with keep = 0000.
// Data lanes whose input tkeep bit is 0 are replaced by IDLE_K and sent as
// control characters (keep bit 0).
// If the frame length does not match, the sticky length_err flag is set:
//   - a frame that ends early is closed with EOF at once;
//   - a frame that runs long is drained and discarded up to its tlast.
//
// Ports
//   sys_clk      rising-edge clock for all logic
//   FIFO_reset   asynchronous, active-high reset
//   frame_start  one-cycle pulse that arms a frame (ignored unless idle)
//   s_tdata/s_tkeep/s_tvalid/s_tready/s_tlast   upstream AXI-Stream
//   m_tdata/m_tkeep/m_tvalid/m_tready           downstream stream (registered)
//   frame_done   one-cycle pulse while the EOF word is handed downstream
//   length_err   sticky frame-length mismatch flag, cleared only by reset

module mm2s_framer #(
   parameter int unsigned LINE_WORDS = 640,
   parameter int unsigned LINES      = 480,
   parameter logic [7:0]  SOF_K      = 8'hFB,
   parameter logic [7:0]  EOL_K      = 8'hF7,
   parameter logic [7:0]  EOF_K      = 8'hFD,
   parameter logic [7:0]  IDLE_K     = 8'hBC
) (
   input  logic        sys_clk,
   input  logic        FIFO_reset,
   input  logic        frame_start,
   input  logic [31:0] s_tdata,
   input  logic [3:0]  s_tkeep,
   input  logic        s_tvalid,
   output logic        s_tready,
   input  logic        s_tlast,
   output logic [31:0] m_tdata,
   output logic [3:0]  m_tkeep,
   output logic        m_tvalid,
   input  logic        m_tready,
   output logic        frame_done,
   output logic        length_err
);

   typedef enum logic [2:0] {
      IDLE,
      SOF,
      DATA,
      EOL,
      EOF,
      DRAIN
   } state_t;

   localparam logic [15:0] WORD_MAX = 16'(LINE_WORDS - 1);
   localparam logic [15:0] LINE_MAX = 16'(LINES - 1);

   state_t      state;
   state_t      state_next;
   logic [15:0] wcnt;
   logic [15:0] wcnt_next;
   logic [15:0] lcnt;
   logic [15:0] lcnt_next;
   logic        err_set;
   logic        out_load;
   logic        emit;
   logic        emit_eof;
   logic [31:0] emit_data;
   logic [3:0]  emit_keep;
   logic [31:0] masked_data;
   logic        out_eof;
   logic        last_word;
   logic        last_line;

   // The output register can take a new word whenever it is empty or its
   // current word is being consumed this cycle.
   assign out_load  = ~m_tvalid | m_tready;
   assign last_word = (wcnt == WORD_MAX);
   assign last_line = (lcnt == LINE_MAX);

   // out_eof tags the word in the output register as the EOF marker, so the
   // done pulse lines up with the downstream handshake of that marker.
   assign frame_done = m_tvalid & m_tready & out_eof;

   // Invalid input lanes become IDLE_K filler.
   always_comb begin
      masked_data = s_tdata;
      for (int i = 0; i < 4; i++) begin
         if (!s_tkeep[i]) begin
            masked_data[8*i +: 8] = IDLE_K;
         end
      end
   end

   // Next-state, counter and emit decisions. Upstream acceptance is expressed
   // directly from s_tvalid and the load condition rather than from s_tready,
   // keeping s_tready a pure output of this block.
   always_comb begin
      state_next = state;
      wcnt_next  = wcnt;
      lcnt_next  = lcnt;
      s_tready   = 1'b0;
      emit       = 1'b0;
      emit_eof   = 1'b0;
      emit_data  = masked_data;
      emit_keep  = s_tkeep;
      err_set    = 1'b0;
      case (state)
         IDLE: begin
            if (frame_start) begin
               state_next = SOF;
            end
         end
         SOF: begin
            emit_data = {4{SOF_K}};
            emit_keep = 4'b0000;
            if (out_load) begin
               emit       = 1'b1;
               state_next = DATA;
            end
         end
         DATA: begin
            s_tready = out_load;
            if (s_tvalid && out_load) begin
               emit = 1'b1;
               if (last_word && last_line) begin
                  wcnt_next = '0;
                  lcnt_next = '0;
                  if (s_tlast) begin
                     state_next = EOF;
                  end else begin
                     err_set    = 1'b1;
                     state_next = DRAIN;
                  end
               end else if (s_tlast) begin
                  // Short frame: close it immediately, no EOL even at a line end.
                  err_set    = 1'b1;
                  state_next = EOF;
               end else if (last_word) begin
                  wcnt_next  = '0;
                  state_next = EOL;
               end else begin
                  wcnt_next = wcnt + 16'd1;
               end
            end
         end
         EOL: begin
            emit_data = {4{EOL_K}};
            emit_keep = 4'b0000;
            if (out_load) begin
               emit       = 1'b1;
               lcnt_next  = lcnt + 16'd1;
               state_next = DATA;
            end
         end
         EOF: begin
            emit_data = {4{EOF_K}};
            emit_keep = 4'b0000;
            emit_eof  = 1'b1;
            if (out_load) begin
               emit       = 1'b1;
               wcnt_next  = '0;
               lcnt_next  = '0;
               state_next = IDLE;
            end
         end
         DRAIN: begin
            // Overlong frame tail is swallowed; nothing reaches the output.
            s_tready = 1'b1;
            if (s_tvalid && s_tlast) begin
               state_next = EOF;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, counters and the sticky length error.
   always_ff @(posedge sys_clk or posedge FIFO_reset) begin
      if (FIFO_reset) begin
         state      <= IDLE;
         wcnt       <= '0;
         lcnt       <= '0;
         length_err <= 1'b0;
      end else begin
         state <= state_next;
         wcnt  <= wcnt_next;
         lcnt  <= lcnt_next;
         if (err_set) begin
            length_err <= 1'b1;
         end
      end
   end

   // Output register: data and keep only change when a new word is loaded,
   // so a stalled word holds steady until the consumer takes it.
   always_ff @(posedge sys_clk or posedge FIFO_reset) begin
      if (FIFO_reset) begin
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
         m_tkeep  <= '0;
         out_eof  <= 1'b0;
      end else if (out_load) begin
         m_tvalid <= emit;
         out_eof  <= emit & emit_eof;
         if (emit) begin
            m_tdata <= emit_data;
            m_tkeep <= emit_keep;
         end
      end
   end

endmodule

// File: tb/tb_mm2s_framer.sv
// tb_mm2s_framer
// Table-driven check of mm2s_framer with LINE_WORDS=4, LINES=2.
// Each table row gives:
//   - the input word count;
//   - the word carrying tlast;
//   - the m_tready pattern;
//   - the expected length_err;
//   - the expected output stream as a 12-character code.
// Stream codes:
//   S = SOF marker, E = EOL marker, F = EOF marker,
//   digit k = data word k with keep F, '.' = padding.
// Hand-written sequences cover byte-lane filling and a reset mid-frame.

module tb_mm2s_framer;

   localparam int CYCLE_BUDGET = 80;

   typedef struct packed {
      int             n_in;
      int             last_at;
      int             mode;
      logic           exp_err;
      logic [95:0]    exp_seq;
   } vec_t;

   logic        sys_clk;
   logic        FIFO_reset;
   logic        frame_start;
   logic [31:0] s_tdata;
   logic [3:0]  s_tkeep;
   logic        s_tvalid;
   logic        s_tready;
   logic        s_tlast;
   logic [31:0] m_tdata;
   logic [3:0]  m_tkeep;
   logic        m_tvalid;
   logic        m_tready;
   logic        frame_done;
   logic        length_err;

   int vectors;
   int miscompares;

   logic [31:0] in_data [16];
   logic [3:0]  in_keep [16];
   logic        in_last [16];
   int          n_in;
   int          consumed;
   int          done_cnt;

   logic [31:0] exp_d [$];
   logic [3:0]  exp_k [$];
   logic [31:0] got_d [$];
   logic [3:0]  got_k [$];

   vec_t tbl [7];

   mm2s_framer #(
      .LINE_WORDS (4),
      .LINES      (2)
   ) dut (
      .sys_clk     (sys_clk),
      .FIFO_reset  (FIFO_reset),
      .frame_start (frame_start),
      .s_tdata     (s_tdata),
      .s_tkeep     (s_tkeep),
      .s_tvalid    (s_tvalid),
      .s_tready    (s_tready),
      .s_tlast     (s_tlast),
      .m_tdata     (m_tdata),
      .m_tkeep     (m_tkeep),
      .m_tvalid    (m_tvalid),
      .m_tready    (m_tready),
      .frame_done  (frame_done),
      .length_err  (length_err)
   );

   // Free-running clock.
   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // One comparison: bumps the vector count and reports a miscompare.
   task automatic compare(input string name, input logic [35:0] actual, input logic [35:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Asserts reset, checks every output sits at its reset value, releases.
   task automatic doReset(input string tag);
      FIFO_reset  = 1'b1;
      frame_start = 1'b0;
      s_tvalid    = 1'b0;
      s_tdata     = '0;
      s_tkeep     = '0;
      s_tlast     = 1'b0;
      m_tready    = 1'b1;
      repeat (2) @(posedge sys_clk);
      #1;
      compare({tag, " reset m_tvalid"}, 36'(m_tvalid), 36'd0);
      compare({tag, " reset m_tdata/keep"}, {m_tkeep, m_tdata}, 36'd0);
      compare({tag, " reset s_tready"}, 36'(s_tready), 36'd0);
      compare({tag, " reset flags"}, 36'({frame_done, length_err}), 36'd0);
      FIFO_reset = 1'b0;
   endtask

   // Sequential input words 1..n, tlast on word last_at.
   task automatic loadInputs(input int n, input int last_at);
      n_in = n;
      for (int i = 0; i < 16; i++) begin
         in_data[i] = 32'(i + 1);
         in_keep[i] = 4'hF;
         in_last[i] = ((i + 1) == last_at);
      end
   endtask

   // Decodes a stream code string into the expected output queues.
   task automatic loadExpected(input logic [95:0] seq);
      logic [7:0] c;
      exp_d.delete();
      exp_k.delete();
      for (int b = 11; b >= 0; b--) begin
         c = seq[b*8 +: 8];
         if (c == "S") begin
            exp_d.push_back(32'hFBFBFBFB);
            exp_k.push_back(4'h0);
         end else if (c == "E") begin
            exp_d.push_back(32'hF7F7F7F7);
            exp_k.push_back(4'h0);
         end else if (c == "F") begin
            exp_d.push_back(32'hFDFDFDFD);
            exp_k.push_back(4'h0);
         end else if (c >= "1" && c <= "9") begin
            exp_d.push_back(32'(c - "0"));
            exp_k.push_back(4'hF);
         end
      end
   endtask

   // Pulses frame_start, streams the inputs under the chosen m_tready
   // pattern and records everything handed downstream. Sampling happens on
   // the falling edge; inputs change 1 time unit after the rising edge.
   // Mode 0: always ready, 1: toggle 1010..., 2: 1100...
   task automatic applyStimulus(input int mode, input int stop_after);
      logic        hs;
      logic        prev_stall;
      logic [31:0] prev_d;
      logic [3:0]  prev_k;
      int          idx;
      got_d.delete();
      got_k.delete();
      done_cnt   = 0;
      idx        = 0;
      prev_stall = 1'b0;
      prev_d     = '0;
      prev_k     = '0;
      @(posedge sys_clk);
      #1 frame_start = 1'b1;
      @(posedge sys_clk);
      #1 frame_start = 1'b0;
      for (int cyc = 0; cyc < CYCLE_BUDGET; cyc++) begin
         if (idx < n_in) begin
            s_tvalid = 1'b1;
            s_tdata  = in_data[idx];
            s_tkeep  = in_keep[idx];
            s_tlast  = in_last[idx];
         end else begin
            s_tvalid = 1'b0;
            s_tdata  = '0;
            s_tkeep  = '0;
            s_tlast  = 1'b0;
         end
         case (mode)
            1:       m_tready = (cyc % 2 == 0);
            2:       m_tready = (cyc % 4 < 2);
            default: m_tready = 1'b1;
         endcase
         @(negedge sys_clk);
         hs = s_tvalid & s_tready;
         if (m_tvalid && m_tready) begin
            got_d.push_back(m_tdata);
            got_k.push_back(m_tkeep);
         end
         if (frame_done) begin
            done_cnt++;
         end
         if (prev_stall) begin
            compare("stall hold", {m_tvalid, m_tkeep, m_tdata[30:0]}, {1'b1, prev_k, prev_d[30:0]});
         end
         prev_stall = m_tvalid & ~m_tready;
         prev_d     = m_tdata;
         prev_k     = m_tkeep;
         @(posedge sys_clk);
         #1;
         if (hs) begin
            idx++;
         end
         if (stop_after > 0 && idx == stop_after) begin
            break;
         end
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      m_tready = 1'b1;
      consumed = idx;
   endtask

   // Compares the recorded stream, done pulses, error flag and input use.
   task automatic checkOutput(input string tag, input logic exp_err);
      int n;
      compare({tag, " out count"}, 36'(got_d.size()), 36'(exp_d.size()));
      n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
      for (int i = 0; i < n; i++) begin
         compare($sformatf("%s word %0d", tag, i), {got_k[i], got_d[i]}, {exp_k[i], exp_d[i]});
      end
      compare({tag, " frame_done pulses"}, 36'(done_cnt), 36'd1);
      compare({tag, " length_err"}, 36'(length_err), 36'(exp_err));
      compare({tag, " inputs consumed"}, 36'(consumed), 36'(n_in));
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      FIFO_reset  = 1'b1;
      frame_start = 1'b0;
      s_tvalid    = 1'b0;
      s_tdata     = '0;
      s_tkeep     = '0;
      s_tlast     = 1'b0;
      m_tready    = 1'b1;
      n_in        = 0;
      consumed    = 0;
      done_cnt    = 0;

      tbl[0] = '{8,  8,  0, 1'b0, "S1234E5678F."};
      tbl[1] = '{8,  8,  1, 1'b0, "S1234E5678F."};
      tbl[2] = '{8,  8,  2, 1'b0, "S1234E5678F."};
      tbl[3] = '{6,  6,  0, 1'b1, "S1234E56F..."};
      tbl[4] = '{10, 10, 0, 1'b1, "S1234E5678F."};
      tbl[5] = '{4,  4,  0, 1'b1, "S1234F......"};
      tbl[6] = '{10, 10, 1, 1'b1, "S1234E5678F."};

      for (int r = 0; r < 7; r++) begin
         doReset($sformatf("row%0d", r));
         loadInputs(tbl[r].n_in, tbl[r].last_at);
         loadExpected(tbl[r].exp_seq);
         applyStimulus(tbl[r].mode, 0);
         checkOutput($sformatf("row%0d", r), tbl[r].exp_err);
      end

      // Partial-keep lanes are filled with IDLE_K and flagged as control.
      doReset("lanes");
      loadInputs(8, 8);
      in_data[0] = 32'hAABBCCDD;
      in_keep[0] = 4'b0011;
      loadExpected("S1234E5678F.");
      exp_d[1] = 32'hBCBCCCDD;
      exp_k[1] = 4'b0011;
      applyStimulus(0, 0);
      checkOutput("lanes", 1'b0);

      // Reset after the third word aborts asynchronously, then a clean frame.
      doReset("abort");
      loadInputs(8, 8);
      applyStimulus(0, 3);
      compare("abort pre-reset m_tvalid", 36'(m_tvalid), 36'd1);
      FIFO_reset = 1'b1;
      #1;
      compare("abort m_tvalid", 36'(m_tvalid), 36'd0);
      compare("abort m_tdata/keep", {m_tkeep, m_tdata}, 36'd0);
      compare("abort s_tready", 36'(s_tready), 36'd0);
      compare("abort flags", 36'({frame_done, length_err}), 36'd0);
      @(posedge sys_clk);
      #1 FIFO_reset = 1'b0;
      loadExpected("S1234E5678F.");
      applyStimulus(0, 0);
      checkOutput("after abort", 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
